// File: rtl/cob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : cob_tag_allocator
// Description : Control-flow order buffer (COB) branch-tag pool. It offers
//               the lowest free tag to the fetch frontend and records each
//               allocated branch's dependency mask. Tags are released on
//               branch-resolution clean/kill broadcasts; a kill also squashes
//               every entry that depends on the killed branch.
// Revision    : 1.0 - initial release
// ============================================================================
module cob_tag_allocator #(
  parameter int COB_DEPTH      = 8,
  parameter int COB_ADDR_WIDTH = $clog2(COB_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  // Allocator client (fetch frontend)
  input  logic                                  coif_allocate,
  input  logic [COB_DEPTH-1:0]                  coif_mask,
  output logic [COB_ADDR_WIDTH-1:0]             coif_index,
  output logic                                  coif_full,
  // Branch resolution bus
  input  logic                                  brb_broadcast,
  input  logic                                  brb_clean,
  input  logic                                  brb_kill,
  input  logic [COB_ADDR_WIDTH-1:0]             brb_tag,
  // Entry i occupies bits [i*(COB_DEPTH+1) +: COB_DEPTH+1] as {valid, branch_mask}
  output logic [COB_DEPTH*(COB_DEPTH+1)-1:0]    cob_data_wire,
  output logic [COB_ADDR_WIDTH:0]               free_count
);

  localparam int ENTRY_W = COB_DEPTH + 1;

  logic [COB_DEPTH-1:0] valid_q;
  logic [COB_DEPTH-1:0] valid_d;
  logic [COB_DEPTH-1:0] mask_q [COB_DEPTH];
  logic [COB_DEPTH-1:0] mask_d [COB_DEPTH];

  logic [COB_DEPTH-1:0] w_tag_bit;
  logic [COB_DEPTH-1:0] w_idx_bit;
  logic [COB_DEPTH-1:0] w_new_mask;
  logic                 w_alloc;
  logic                 w_hit;
  logic                 w_kill;
  logic                 w_clean;

  // Lowest-numbered free entry; scanning downward lets the lowest one win.
  always_comb begin
    coif_index = '0;
    for (int i = COB_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        coif_index = i[COB_ADDR_WIDTH-1:0];
      end
    end
  end

  // Pool occupancy status.
  always_comb begin
    coif_full  = &valid_q;
    free_count = '0;
    for (int i = 0; i < COB_DEPTH; i++) begin
      free_count = free_count + {{COB_ADDR_WIDTH{1'b0}}, ~valid_q[i]};
    end
  end

  // Decode allocate/resolve requests; a broadcast on an invalid tag is a no-op
  // and kill takes priority over clean.
  always_comb begin
    w_tag_bit          = '0;
    w_tag_bit[brb_tag] = 1'b1;
    w_idx_bit             = '0;
    w_idx_bit[coif_index] = 1'b1;
    w_alloc = coif_allocate & ~coif_full;
    w_hit   = brb_broadcast & valid_q[brb_tag];
    w_kill  = w_hit & brb_kill;
    w_clean = w_hit & brb_clean & ~brb_kill;
    // A new branch never depends on itself nor on the branch resolving now.
    w_new_mask = coif_mask & ~w_idx_bit & (brb_broadcast ? ~w_tag_bit : {COB_DEPTH{1'b1}});
  end

  // Next-state for every entry. Allocation is applied last: the allocated
  // index is free this cycle, so it can never be the resolving tag and the
  // new correct-path entry is never squashed.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < COB_DEPTH; i++) begin
      mask_d[i] = mask_q[i];
      if (w_kill) begin
        if ((i == int'(brb_tag)) || (valid_q[i] && mask_q[i][brb_tag])) begin
          valid_d[i] = 1'b0;
          mask_d[i]  = '0;
        end else begin
          mask_d[i]  = mask_q[i] & ~w_tag_bit;
        end
      end else if (w_clean) begin
        if (i == int'(brb_tag)) begin
          valid_d[i] = 1'b0;
          mask_d[i]  = '0;
        end else begin
          mask_d[i]  = mask_q[i] & ~w_tag_bit;
        end
      end
      if (w_alloc && (i == int'(coif_index))) begin
        valid_d[i] = 1'b1;
        mask_d[i]  = w_new_mask;
      end
    end
  end

  // State register; reset clears the whole pool and overrides any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < COB_DEPTH; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < COB_DEPTH; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end

  // Registered state exposed directly so a kill-cycle reader sees pre-kill masks.
  generate
    for (genvar g = 0; g < COB_DEPTH; g++) begin : g_pack
      assign cob_data_wire[g*ENTRY_W +: ENTRY_W] = {valid_q[g], mask_q[g]};
    end
  endgenerate

`ifndef SYNTHESIS
  // Protocol checks on the client and resolution bus.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(coif_allocate && coif_full))
        else $warning("cob_tag_allocator: allocate while full ignored");
      assert (!(brb_broadcast && brb_clean && brb_kill))
        else $warning("cob_tag_allocator: clean and kill together, kill taken");
      assert (!(brb_broadcast && !valid_q[brb_tag]))
        else $warning("cob_tag_allocator: broadcast on invalid tag ignored");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cob_tag_allocator
// Description : Directed self-checking bench for cob_tag_allocator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cob_tag_allocator;

  localparam int D  = 8;
  localparam int AW = 3;
  localparam int EW = D + 1;

  logic              clk;
  logic              rst;
  logic              coif_allocate;
  logic [D-1:0]      coif_mask;
  logic [AW-1:0]     coif_index;
  logic              coif_full;
  logic              brb_broadcast;
  logic              brb_clean;
  logic              brb_kill;
  logic [AW-1:0]     brb_tag;
  logic [D*EW-1:0]   cob_data_wire;
  logic [AW:0]       free_count;

  int n_checks;
  int n_fail;

  cob_tag_allocator #(.COB_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .coif_allocate (coif_allocate),
    .coif_mask     (coif_mask),
    .coif_index    (coif_index),
    .coif_full     (coif_full),
    .brb_broadcast (brb_broadcast),
    .brb_clean     (brb_clean),
    .brb_kill      (brb_kill),
    .brb_tag       (brb_tag),
    .cob_data_wire (cob_data_wire),
    .free_count    (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [D-1:0] ent_mask(int i);
    return cob_data_wire[i*EW +: D];
  endfunction

  function automatic logic [D-1:0] valid_vec();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = cob_data_wire[i*EW + D];
    return v;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    coif_allocate = 1'b0;
    coif_mask     = '0;
    brb_broadcast = 1'b0;
    brb_clean     = 1'b0;
    brb_kill      = 1'b0;
    brb_tag       = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Allocate n entries with chain masks 0x00, 0x01, 0x03, ...
  task automatic fill_chain(int n);
    for (int k = 0; k < n; k++) begin
      coif_allocate = 1'b1;
      coif_mask     = D'((1 << k) - 1);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (coif_index !== 3'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", coif_index); end
    n_checks++;
    if (coif_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", coif_full); end
    n_checks++;
    if (free_count !== 4'd8) begin n_fail++; $display("FAIL reset_free: got %0d expected 8", free_count); end
    n_checks++;
    if (cob_data_wire !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", cob_data_wire); end
  endtask

  task automatic test_fill();
    logic [D*EW-1:0] exp_data;
    do_reset();
    for (int k = 0; k < D; k++) begin
      n_checks++;
      if (coif_index !== AW'(k)) begin n_fail++; $display("FAIL fill_index_%0d: got %0d expected %0d", k, coif_index, k); end
      coif_allocate = 1'b1;
      coif_mask     = D'((1 << k) - 1);
      step();
    end
    idle();
    n_checks++;
    if (coif_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", coif_full); end
    n_checks++;
    if (free_count !== 4'd0) begin n_fail++; $display("FAIL fill_free: got %0d expected 0", free_count); end
    n_checks++;
    if (coif_index !== 3'd0) begin n_fail++; $display("FAIL fill_index_full: got %0d expected 0", coif_index); end
    n_checks++;
    if (ent_mask(7) !== 8'h7F) begin n_fail++; $display("FAIL fill_mask7: got %h expected 7f", ent_mask(7)); end
    // A ninth allocate while full must leave every entry untouched.
    coif_allocate = 1'b1;
    coif_mask     = 8'hFF;
    step();
    idle();
    for (int i = 0; i < D; i++) exp_data[i*EW +: EW] = {1'b1, D'((1 << i) - 1)};
    n_checks++;
    if (cob_data_wire !== exp_data) begin n_fail++; $display("FAIL full_alloc_ignored: got %h expected %h", cob_data_wire, exp_data); end
    n_checks++;
    if (free_count !== 4'd0) begin n_fail++; $display("FAIL full_alloc_free: got %0d expected 0", free_count); end
  endtask

  task automatic test_clean();
    do_reset();
    fill_chain(D);
    brb_broadcast = 1'b1;
    brb_clean     = 1'b1;
    brb_tag       = 3'd3;
    step();
    idle();
    n_checks++;
    if (valid_vec() !== 8'hF7) begin n_fail++; $display("FAIL clean_valid: got %h expected f7", valid_vec()); end
    n_checks++;
    if (coif_index !== 3'd3) begin n_fail++; $display("FAIL clean_index: got %0d expected 3", coif_index); end
    n_checks++;
    if (free_count !== 4'd1) begin n_fail++; $display("FAIL clean_free: got %0d expected 1", free_count); end
    n_checks++;
    if (ent_mask(7) !== 8'h77) begin n_fail++; $display("FAIL clean_mask7: got %h expected 77", ent_mask(7)); end
    n_checks++;
    if (ent_mask(4) !== 8'h07) begin n_fail++; $display("FAIL clean_mask4: got %h expected 07", ent_mask(4)); end
    n_checks++;
    if (ent_mask(2) !== 8'h03) begin n_fail++; $display("FAIL clean_mask2: got %h expected 03", ent_mask(2)); end
    n_checks++;
    if (ent_mask(3) !== 8'h00) begin n_fail++; $display("FAIL clean_mask3: got %h expected 00", ent_mask(3)); end
  endtask

  task automatic test_kill();
    do_reset();
    fill_chain(D);
    brb_broadcast = 1'b1;
    brb_kill      = 1'b1;
    brb_tag       = 3'd2;
    #1;
    n_checks++;
    if (ent_mask(2) !== 8'h03) begin n_fail++; $display("FAIL kill_premask: got %h expected 03", ent_mask(2)); end
    step();
    idle();
    n_checks++;
    if (valid_vec() !== 8'h03) begin n_fail++; $display("FAIL kill_valid: got %h expected 03", valid_vec()); end
    n_checks++;
    if (ent_mask(0) !== 8'h00) begin n_fail++; $display("FAIL kill_mask0: got %h expected 00", ent_mask(0)); end
    n_checks++;
    if (ent_mask(1) !== 8'h01) begin n_fail++; $display("FAIL kill_mask1: got %h expected 01", ent_mask(1)); end
    n_checks++;
    if (ent_mask(7) !== 8'h00) begin n_fail++; $display("FAIL kill_mask7: got %h expected 00", ent_mask(7)); end
    n_checks++;
    if (free_count !== 4'd6) begin n_fail++; $display("FAIL kill_free: got %0d expected 6", free_count); end
    n_checks++;
    if (coif_index !== 3'd2) begin n_fail++; $display("FAIL kill_index: got %0d expected 2", coif_index); end
  endtask

  task automatic test_alloc_kill();
    do_reset();
    fill_chain(6);
    n_checks++;
    if (coif_index !== 3'd6) begin n_fail++; $display("FAIL akill_pre_index: got %0d expected 6", coif_index); end
    coif_allocate = 1'b1;
    coif_mask     = 8'h3F;
    brb_broadcast = 1'b1;
    brb_kill      = 1'b1;
    brb_tag       = 3'd5;
    step();
    idle();
    n_checks++;
    if (valid_vec() !== 8'h5F) begin n_fail++; $display("FAIL akill_valid: got %h expected 5f", valid_vec()); end
    n_checks++;
    if (ent_mask(6) !== 8'h1F) begin n_fail++; $display("FAIL akill_mask6: got %h expected 1f", ent_mask(6)); end
    n_checks++;
    if (ent_mask(4) !== 8'h0F) begin n_fail++; $display("FAIL akill_mask4: got %h expected 0f", ent_mask(4)); end
    n_checks++;
    if (free_count !== 4'd2) begin n_fail++; $display("FAIL akill_free: got %0d expected 2", free_count); end
    n_checks++;
    if (coif_index !== 3'd5) begin n_fail++; $display("FAIL akill_index: got %0d expected 5", coif_index); end
  endtask

  task automatic test_alloc_clean();
    do_reset();
    fill_chain(1);
    coif_allocate = 1'b1;
    coif_mask     = 8'h01;
    brb_broadcast = 1'b1;
    brb_clean     = 1'b1;
    brb_tag       = 3'd0;
    step();
    idle();
    n_checks++;
    if (valid_vec() !== 8'h02) begin n_fail++; $display("FAIL aclean_valid: got %h expected 02", valid_vec()); end
    n_checks++;
    if (ent_mask(1) !== 8'h00) begin n_fail++; $display("FAIL aclean_mask1: got %h expected 00", ent_mask(1)); end
    n_checks++;
    if (coif_index !== 3'd0) begin n_fail++; $display("FAIL aclean_index: got %0d expected 0", coif_index); end
    n_checks++;
    if (free_count !== 4'd7) begin n_fail++; $display("FAIL aclean_free: got %0d expected 7", free_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_chain(4);
    n_checks++;
    if (free_count !== 4'd4) begin n_fail++; $display("FAIL rmid_pre_free: got %0d expected 4", free_count); end
    rst           = 1'b1;
    coif_allocate = 1'b1;
    coif_mask     = 8'h0F;
    brb_broadcast = 1'b1;
    brb_kill      = 1'b1;
    brb_tag       = 3'd1;
    step();
    rst = 1'b0;
    idle();
    n_checks++;
    if (cob_data_wire !== '0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", cob_data_wire); end
    n_checks++;
    if (free_count !== 4'd8) begin n_fail++; $display("FAIL rmid_free: got %0d expected 8", free_count); end
    n_checks++;
    if (coif_index !== 3'd0) begin n_fail++; $display("FAIL rmid_index: got %0d expected 0", coif_index); end
    n_checks++;
    if (coif_full !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %0b expected 0", coif_full); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    step();
    test_reset();
    test_fill();
    test_clean();
    test_kill();
    test_alloc_kill();
    test_alloc_clean();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cob_tag_allocator.md
Name: cob_tag_allocator

Overview:
- Responder side of the fetch-stage branch-tag allocation handshake.
- Owns the control-flow order buffer (COB) tag pool. It hands out a free branch tag (coif_index) each cycle, records each allocated branch's dependency mask, and exposes all entries on cob_data_wire for kill-time mask recovery.
- Frees tags on branch-resolution-bus clean and kill broadcasts. A kill also squashes every entry that depends on the killed branch.
- Sits between the fetch frontend (allocator client) and the backend branch-resolution bus.

Parameters:
- COB_DEPTH, 8, number of branch tags / COB entries; power of two, minimum 2.
- COB_ADDR_WIDTH, $clog2(COB_DEPTH), tag width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- coif_allocate  input  1  client claims the tag currently on coif_index
- coif_mask  input  COB_DEPTH  dependency mask of the allocating branch (older unresolved tags)
- coif_index  output  COB_ADDR_WIDTH  tag offered for the next allocation
- coif_full  output  1  no free tag
- brb_broadcast  input  1  resolution bus valid
- brb_clean  input  1  branch brb_tag predicted correctly
- brb_kill  input  1  branch brb_tag mispredicted
- brb_tag  input  COB_ADDR_WIDTH  resolving tag
- cob_data_wire  output  COB_DEPTH x cob_entry_t  per-entry {valid, branch_mask[COB_DEPTH]}, registered state, combinational read
- free_count  output  COB_ADDR_WIDTH+1  number of invalid entries

Behaviour:
- State: valid[COB_DEPTH] and mask[COB_DEPTH][COB_DEPTH], all flops. cob_data_wire is a direct view of this state, with no bypass of same-cycle updates.
- Reset:
  - All valid = 0 and all masks = 0.
  - After the reset cycle: coif_index = 0, coif_full = 0, free_count = COB_DEPTH.
- coif_index:
  - Lowest-numbered entry with valid = 0, computed from current state only.
  - A tag freed this cycle is offered no earlier than the next cycle.
  - When full, coif_index = 0 and is don't-care.
- coif_full = &valid. free_count = popcount(~valid).
- Allocate (coif_allocate & ~coif_full), effective next edge:
  - valid[coif_index] <= 1.
  - mask[coif_index] <= coif_mask, with bit coif_index forced to 0.
  - If brb_broadcast is high the same cycle, bit brb_tag is also forced to 0.
- Allocate while full:
  - Ignored; no state change.
  - Simulation assertion fires.
- Clean (brb_broadcast & brb_clean, tag t valid), next edge:
  - valid[t] <= 0 and mask[t] <= 0.
  - Bit t is cleared in every entry's mask.
- Kill (brb_broadcast & brb_kill, tag t valid), next edge:
  - valid[t] <= 0.
  - Every entry i with valid[i] & mask[i][t] <= invalid, mask cleared.
  - Bit t is cleared in all surviving masks.
  - Entries that do not depend on t are unaffected.
  - The client reads cob_data_wire[t].branch_mask during the kill cycle, so entry t must hold its pre-kill contents until the edge.
- Kill precedence: kill wins if clean and kill are both asserted, and the simulation assertion fires.
- Broadcast on an invalid tag: no-op; simulation assertion fires.
- Simultaneous allocate + kill:
  - The new entry is never squashed; allocations in the kill cycle are correct-path.
  - Its mask bit t is cleared.
  - The newly allocated index is never the killed tag, since t was valid.
- Simultaneous allocate + clean: the new entry is written and bit t is cleared in its mask.
- Latency: all updates are visible on outputs one cycle after the triggering input.
- Throughput: one allocation and one resolution per cycle.
- Reset mid-operation: rst overrides allocate and broadcast in the same cycle; all state returns to reset values.

Test Plan:
- Reset, then allocate 8 consecutive cycles with masks 0x00, 0x01, 0x03, …, 0x7F -> coif_index sequence 0..7. After the 8th allocation coif_full = 1 and free_count = 0; a 9th allocate changes nothing.
- From full, clean tag 3 -> next cycle valid[3] = 0, coif_index = 3, free_count = 1, and bit 3 cleared in the masks of entries 4..7 (entry 7 mask = 0x77).
- From full with chain masks, kill tag 2 while cob_data_wire[2].branch_mask reads 0x03 in that cycle -> next cycle entries 2..7 invalid, entries 0,1 valid with masks 0x00 and 0x01, free_count = 6, coif_index = 2.
- Kill tag 5 in the same cycle as allocate at index 6 with coif_mask 0x3F -> entry 6 survives with mask 0x1F; entry 5 and its dependents (none others) are invalid.
- Clean tag 0 in the same cycle as allocate at index 1 with coif_mask 0x01 -> entry 1 mask = 0x00; coif_index next cycle = 0.
- Assert rst during a kill broadcast with 4 valid entries -> next cycle all invalid, free_count = 8, coif_index = 0, coif_full = 0.
